lock_access_ctrl: RTL and testbench
===================================

# lock_access_ctrl

Access controller for the serial-code lock detector: gates keypad bits into the detector, judges each code attempt at its frame boundary, and holds the door open for a fixed window. Counts failed attempts, enforces a lockout period with a one-cycle alarm pulse after too many failures, and clears the detector between attempts. Sits between the keypad front end and the detector FSM.

## Interface

- MAX_TRIES, 3: consecutive failed attempts that trigger lockout (>=1)
- OPEN_CYCLES, 8: cycles door_open stays high per successful attempt (>=1)
- LOCKOUT_CYCLES, 16: cycles locked_out stays high (>=1)
- clk  input  1  single clock, all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- key_valid  input  1  a code bit is presented this cycle
- key_bit  input  1  code bit value
- frame_end  input  1  user has finished the current attempt (one-cycle pulse)
- force_lock  input  1  relock immediately while open
- det_unlock  input  1  detector's unlock output
- det_en  output  1  advance detector this cycle
- det_data  output  1  bit forwarded to detector
- det_clr  output  1  synchronous clear to detector
- door_open  output  1  door release
- locked_out  output  1  lockout active, input ignored
- alarm  output  1  one-cycle pulse on lockout entry
- fail_cnt  output  $clog2(MAX_TRIES+1)  consecutive failed attempts

## Operation

- States: CLR, ENTRY, OPEN, LOCKOUT. Outputs decoded from state (Moore), except det_en/det_data.
- CLR: det_clr=1 for exactly one cycle; next state ENTRY.
- ENTRY: det_en=key_valid, det_data=key_bit; otherwise det_en=0, det_data=0.
- ENTRY on frame_end=1:
  - If det_unlock=1: go to OPEN, fail_cnt<=0, timer<=OPEN_CYCLES-1.
  - Else if fail_cnt+1==MAX_TRIES: go to LOCKOUT, fail_cnt<=MAX_TRIES, timer<=LOCKOUT_CYCLES-1, alarm=1 on the next cycle only.
  - Else: fail_cnt<=fail_cnt+1, go to CLR.
- det_unlock high without frame_end does not open the door.
- OPEN: door_open=1; key_valid/frame_end ignored (det_en=0).
  - timer==0 or force_lock=1: go to CLR.
  - Otherwise timer decrements.
- LOCKOUT: locked_out=1; all inputs ignored, including force_lock.
  - timer==0: fail_cnt<=0, go to CLR.
  - Otherwise timer decrements.
- Timer width: $clog2(max(OPEN_CYCLES,LOCKOUT_CYCLES)). It never wraps; it is only loaded on state entry.
- fail_cnt saturates at MAX_TRIES and never exceeds it.

## Timing

- Reset asserted: state=CLR, fail_cnt=0, timer=0, door_open=0, locked_out=0, alarm=0, det_en=0, det_data=0, det_clr=1. First edge after release moves to ENTRY.
- Reset mid-OPEN or mid-LOCKOUT: outputs drop immediately (asynchronously) to reset values, and the fail count is lost.
- key_valid and frame_end in the same ENTRY cycle:
  - The bit is forwarded (det_en=1).
  - The verdict uses det_unlock as sampled that cycle, i.e. before the detector absorbs the bit.
- Attempt latency: frame_end at edge N is followed by door_open/locked_out/det_clr high from edge N+1.
- door_open is high for exactly OPEN_CYCLES cycles unless force_lock is asserted. force_lock in OPEN cycle k drops door_open at the next edge.
- locked_out is high for exactly LOCKOUT_CYCLES cycles. ENTRY resumes LOCKOUT_CYCLES+1 cycles after entry, with one CLR cycle in between.
- key_valid in CLR, OPEN or LOCKOUT is dropped, not buffered.

## Test plan

- Reset release, then frame_end with det_unlock=1 at cycle 5 -> door_open high cycles 6-13 (8 cycles), det_clr cycle 14, fail_cnt=0 throughout.
- Three frame_end pulses with det_unlock=0 -> fail_cnt 1, 2, then 3. On the third: alarm one cycle, locked_out 16 cycles, det_clr once after, fail_cnt=0 at ENTRY.
- During LOCKOUT drive key_valid=1, frame_end=1, force_lock=1 -> det_en=0, no state change, locked_out length unaffected.
- Two failures, then success -> fail_cnt returns 2->0 at open. A further failure gives fail_cnt=1, not lockout.
- OPEN with force_lock at open cycle 3 -> door_open low from the next edge, det_clr one cycle, ENTRY.
- Assert reset (low) mid-lockout, cycle 7 of 16 -> locked_out=0 and fail_cnt=0 immediately, det_clr=1 until release, then normal ENTRY.

Source files
------------

// File: rtl/lock_access_ctrl.sv
// lock_access_ctrl: gates keypad bits into the code detector, judges each
// attempt at frame_end, holds the door open for a fixed window and enforces
// a lockout (with a one-cycle alarm) after too many consecutive failures.
module lock_access_ctrl #(
  parameter int MAX_TRIES      = 3,
  parameter int OPEN_CYCLES    = 8,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           reset,      // active-low, asynchronous
  input  logic                           key_valid,
  input  logic                           key_bit,
  input  logic                           frame_end,
  input  logic                           force_lock,
  input  logic                           det_unlock,
  output logic                           det_en,
  output logic                           det_data,
  output logic                           det_clr,
  output logic                           door_open,
  output logic                           locked_out,
  output logic                           alarm,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt
);

  localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int FW   = $clog2(MAX_TRIES + 1);

  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW:0]   TRIES_W   = (FW+1)'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_CLR,
    S_ENTRY,
    S_OPEN,
    S_LOCKOUT
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [FW-1:0] r_fail,  w_fail_nxt;
  logic          r_alarm, w_alarm_nxt;
  logic [FW:0]   w_fail_inc;

  assign w_fail_inc = {1'b0, r_fail} + (FW+1)'(1);
  assign alarm      = r_alarm;
  assign fail_cnt   = r_fail;

  // State, timer, failure count and alarm registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_CLR;
      r_timer <= '0;
      r_fail  <= '0;
      r_alarm <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_fail  <= w_fail_nxt;
      r_alarm <= w_alarm_nxt;
    end
  end

  // Next-state logic plus Moore outputs; det_en/det_data pass through in ENTRY.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_fail_nxt  = r_fail;
    w_alarm_nxt = 1'b0;
    det_en      = 1'b0;
    det_data    = 1'b0;
    det_clr     = 1'b0;
    door_open   = 1'b0;
    locked_out  = 1'b0;
    unique case (r_state)
      S_CLR: begin
        det_clr     = 1'b1;
        w_state_nxt = S_ENTRY;
      end
      S_ENTRY: begin
        det_en   = key_valid;
        det_data = key_valid & key_bit;
        if (frame_end) begin
          if (det_unlock) begin
            w_state_nxt = S_OPEN;
            w_fail_nxt  = '0;
            w_timer_nxt = OPEN_LOAD;
          end else if (w_fail_inc == TRIES_W) begin
            w_state_nxt = S_LOCKOUT;
            w_fail_nxt  = FW'(MAX_TRIES);
            w_timer_nxt = LOCK_LOAD;
            w_alarm_nxt = 1'b1;
          end else begin
            w_fail_nxt  = w_fail_inc[FW-1:0];
            w_state_nxt = S_CLR;
          end
        end
      end
      S_OPEN: begin
        door_open = 1'b1;
        if (r_timer == '0 || force_lock) begin
          w_state_nxt = S_CLR;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      S_LOCKOUT: begin
        locked_out = 1'b1;
        if (r_timer == '0) begin
          w_fail_nxt  = '0;
          w_state_nxt = S_CLR;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      default: w_state_nxt = S_CLR;
    endcase
  end

endmodule

// File: tb/tb_lock_access_ctrl.sv
// Scoreboard bench for lock_access_ctrl: a behavioural model predicts every
// cycle's outputs; a negedge monitor pops and compares against the DUT.
module tb_lock_access_ctrl;

  localparam int MAX_TRIES      = 3;
  localparam int OPEN_CYCLES    = 8;
  localparam int LOCKOUT_CYCLES = 16;
  localparam int FW             = $clog2(MAX_TRIES + 1);
  localparam int VW             = 6 + FW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          key_valid = 1'b0, key_bit = 1'b0, frame_end = 1'b0;
  logic          force_lock = 1'b0, det_unlock = 1'b0;
  logic          det_en, det_data, det_clr, door_open, locked_out, alarm;
  logic [FW-1:0] fail_cnt;

  lock_access_ctrl #(
    .MAX_TRIES     (MAX_TRIES),
    .OPEN_CYCLES   (OPEN_CYCLES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_bit   (key_bit),
    .frame_end (frame_end),
    .force_lock(force_lock),
    .det_unlock(det_unlock),
    .det_en    (det_en),
    .det_data  (det_data),
    .det_clr   (det_clr),
    .door_open (door_open),
    .locked_out(locked_out),
    .alarm     (alarm),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] exp_q[$];

  // Model: remaining door/lockout cycles, pending clear, consecutive failures.
  int m_open_left = 0;
  int m_lock_left = 0;
  bit m_clr       = 1'b1;
  int m_fails     = 0;
  bit m_alarm     = 1'b0;

  task automatic cyc(input bit rn, input bit kv, input bit kb, input bit fe,
                     input bit fl, input bit du);
    bit entry;
    logic [VW-1:0] e;
    @(posedge clk);
    #1;
    reset = rn; key_valid = kv; key_bit = kb; frame_end = fe;
    force_lock = fl; det_unlock = du;
    if (!rn) begin
      m_open_left = 0; m_lock_left = 0; m_clr = 1'b1; m_fails = 0; m_alarm = 1'b0;
    end
    entry = (m_open_left == 0) && (m_lock_left == 0) && !m_clr;
    e = {entry && kv, entry && kv && kb, m_clr, m_open_left > 0,
         m_lock_left > 0, m_alarm, FW'(m_fails)};
    exp_q.push_back(e);
    if (!rn) return;
    m_alarm = 1'b0;
    if (m_clr) begin
      m_clr = 1'b0;
    end else if (m_open_left > 0) begin
      if (m_open_left == 1 || fl) begin m_open_left = 0; m_clr = 1'b1; end
      else m_open_left--;
    end else if (m_lock_left > 0) begin
      if (m_lock_left == 1) begin m_lock_left = 0; m_fails = 0; m_clr = 1'b1; end
      else m_lock_left--;
    end else if (fe) begin
      if (du) begin
        m_open_left = OPEN_CYCLES; m_fails = 0;
      end else if (m_fails + 1 == MAX_TRIES) begin
        m_lock_left = LOCKOUT_CYCLES; m_fails = MAX_TRIES; m_alarm = 1'b1;
      end else begin
        m_fails++; m_clr = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic attempt(input bit du);
    cyc(1, 1, 1, 1, 0, du);
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    logic [VW-1:0] act;
    logic [VW-1:0] want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      act  = {det_en, det_data, det_clr, door_open, locked_out, alarm, fail_cnt};
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL outputs t=%0t {en,data,clr,open,lock,alarm,fail} actual=%b required=%b",
                 $time, act, want);
      end
    end
  end

  initial begin
    // Reset held, then release.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    idle(4);
    // Successful attempt, full open window.
    attempt(1);
    idle(12);
    // Three failures -> lockout, hammered with inputs during lockout.
    attempt(0); idle(2);
    attempt(0); idle(2);
    attempt(0);
    for (int i = 0; i < LOCKOUT_CYCLES; i++) cyc(1, 1, 1, 1, 1, 1);
    idle(3);
    // det_unlock without frame_end does nothing.
    for (int i = 0; i < 4; i++) cyc(1, 1, i[0], 0, 0, 1);
    // Two failures, success, then one failure.
    attempt(0); idle(2);
    attempt(0); idle(2);
    attempt(1); idle(OPEN_CYCLES + 2);
    attempt(0); idle(3);
    // Success with force_lock in open cycle 3.
    attempt(1); idle(2);
    cyc(1, 0, 0, 0, 1, 0);
    idle(4);
    // Reset in lockout cycle 7.
    attempt(0); idle(2);
    attempt(0); idle(2);
    attempt(0); idle(6);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    idle(3);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 299) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
    end
    idle(2);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
